// File: rtl/dds_dac_tlc5615.sv
// dds_dac_tlc5615
// Serial driver for a TLC5615-class 10-bit DAC. Accepts one 10-bit sample per
// valid/ready handshake and shifts it out as a 16-bit frame
// (4 zero bits, 10 data bits MSB first, 2 zero bits).
//
// State table
//   state | meaning
//   IDLE  | cs_n high, sclk low, ready for a sample
//   SHIFT | cs_n low, 16 sclk periods generated from the clk divider
//   GAP   | cs_n high for CS_GAP cycles before the next frame
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sample       waveform sample from the DDS stage
//   sample_valid sample is valid
//   sample_ready block can accept a sample (state == IDLE)
//   dac_sclk     DAC serial clock, idles low
//   dac_din      DAC serial data, changes on sclk falling edge
//   dac_cs_n     DAC chip select, active low
//   frame_done   one-cycle pulse after the last sclk falling edge
module dds_dac_tlc5615 #(
   parameter int CLK_DIV   = 2,
   parameter int CS_GAP    = 2,
   parameter bit TWOS_COMP = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] sample,
   input  logic       sample_valid,
   output logic       sample_ready,
   output logic       dac_sclk,
   output logic       dac_din,
   output logic       dac_cs_n,
   output logic       frame_done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = $clog2(CS_GAP + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t             state_q, state_d;
   logic [15:0]        shreg_q, shreg_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [4:0]         edge_cnt_q, edge_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               sclk_q, sclk_d;
   logic               din_q, din_d;
   logic               cs_n_q, cs_n_d;
   logic               done_q, done_d;

   logic [9:0]         s_word;
   logic [15:0]        frame_w;

   // Offset-binary conversion: flipping the sign bit maps -512..511 onto 0..1023.
   always_comb begin
      s_word  = TWOS_COMP ? {~sample[9], sample[8:0]} : sample;
      frame_w = {4'b0000, s_word, 2'b00};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
         gap_cnt_q  <= '0;
         sclk_q     <= 1'b0;
         din_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         div_cnt_q  <= div_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         sclk_q     <= sclk_d;
         din_q      <= din_d;
         cs_n_q     <= cs_n_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      div_cnt_d  = div_cnt_q;
      edge_cnt_d = edge_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      sclk_d     = sclk_q;
      din_d      = din_q;
      cs_n_d     = cs_n_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            din_d  = 1'b0;
            if (sample_valid) begin
               state_d    = SHIFT;
               shreg_d    = frame_w;
               din_d      = frame_w[15];
               cs_n_d     = 1'b0;
               div_cnt_d  = '0;
               edge_cnt_d = '0;
            end
         end

         SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sclk_d    = ~sclk_q;
               // Falling toggle: present the next bit, DAC samples on the rise.
               if (sclk_q) begin
                  shreg_d    = {shreg_q[14:0], 1'b0};
                  din_d      = shreg_q[14];
                  edge_cnt_d = edge_cnt_q + 5'd1;
                  if (edge_cnt_q == 5'd15) begin
                     state_d   = GAP;
                     cs_n_d    = 1'b1;
                     din_d     = 1'b0;
                     done_d    = 1'b1;
                     gap_cnt_d = '0;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         GAP: begin
            cs_n_d = 1'b1;
            din_d  = 1'b0;
            if (gap_cnt_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign sample_ready = (state_q == IDLE);
   assign dac_sclk     = sclk_q;
   assign dac_din      = din_q;
   assign dac_cs_n     = cs_n_q;
   assign frame_done   = done_q;

endmodule

// File: tb/tb_dds_dac_tlc5615.sv
// Bench for dds_dac_tlc5615: three instances (default divider, fastest
// divider, two's-complement input) checked every cycle against a timing model
// derived from the frame schedule, plus literal frame words and timings.
module tb_dds_dac_tlc5615;

   localparam int NI = 3;

   function automatic int dv(input int k);
      case (k) 0: return 2; 1: return 1; default: return 3; endcase
   endfunction
   function automatic int gp(input int k);
      case (k) 0: return 2; 1: return 1; default: return 3; endcase
   endfunction
   function automatic bit tc(input int k);
      return (k == 2);
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [9:0]    smp [NI];
   logic [NI-1:0] vld;
   wire  [NI-1:0] rdy, sclk, din, csn, fd;

   dds_dac_tlc5615 #(.CLK_DIV(2), .CS_GAP(2), .TWOS_COMP(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .sample(smp[0]), .sample_valid(vld[0]),
      .sample_ready(rdy[0]), .dac_sclk(sclk[0]), .dac_din(din[0]),
      .dac_cs_n(csn[0]), .frame_done(fd[0]));
   dds_dac_tlc5615 #(.CLK_DIV(1), .CS_GAP(1), .TWOS_COMP(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .sample(smp[1]), .sample_valid(vld[1]),
      .sample_ready(rdy[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
      .dac_cs_n(csn[1]), .frame_done(fd[1]));
   dds_dac_tlc5615 #(.CLK_DIV(3), .CS_GAP(3), .TWOS_COMP(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .sample(smp[2]), .sample_valid(vld[2]),
      .sample_ready(rdy[2]), .dac_sclk(sclk[2]), .dac_din(din[2]),
      .dac_cs_n(csn[2]), .frame_done(fd[2]));

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Model: busy flag, cycles since accept (1 = first cycle after the accept edge),
   // and the frame word fixed at accept.
   bit          busy   [NI];
   int          mn     [NI];
   logic [15:0] mframe [NI];
   int          acc_cnt  [NI];
   int          acc_last [NI];

   // Monitor state
   logic [15:0] cap    [NI];
   int          capn   [NI];
   logic        psclk  [NI];
   logic        prdy   [NI];
   logic [15:0] hist   [NI][64];
   int          fdh    [NI][64];
   int          nw     [NI];
   int          gapc   [NI];
   int          last_gap [NI];
   int          rdy_last [NI];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         busy[k] = 0; mn[k] = 0; mframe[k] = '0; acc_cnt[k] = 0; acc_last[k] = 0;
         cap[k] = '0; capn[k] = 0; psclk[k] = 0; prdy[k] = 1; nw[k] = 0;
         gapc[k] = 0; last_gap[k] = 0; rdy_last[k] = 0;
         smp[k] = '0;
      end
      vld = '0;
   end

   always @(posedge clk) begin
      logic [9:0] s;
      cyc++;
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            busy[k] = 0;
         end else if (busy[k]) begin
            mn[k]++;
            if (mn[k] == 32 * dv(k) + 1 + gp(k)) busy[k] = 0;
         end else if (vld[k]) begin
            busy[k] = 1;
            mn[k] = 1;
            s = tc(k) ? {~smp[k][9], smp[k][8:0]} : smp[k];
            mframe[k] = {4'b0000, s, 2'b00};
            acc_cnt[k]++;
            acc_last[k] = cyc;
         end
      end
   end

   // Per-cycle compare of {ready, cs_n, sclk, din, frame_done} plus frame capture.
   always @(negedge clk) begin
      logic [4:0] expv, actv;
      int ph, d;
      for (int k = 0; k < NI; k++) begin
         d = dv(k);
         if (!rst_n || !busy[k]) begin
            expv = 5'b11000;
         end else if (mn[k] <= 32 * d) begin
            ph = (mn[k] - 1) / d;
            expv = {1'b0, 1'b0, ph[0], mframe[k][15 - ph / 2], 1'b0};
         end else if (mn[k] == 32 * d + 1) begin
            expv = 5'b01001;
         end else begin
            expv = 5'b01000;
         end
         actv = {rdy[k], csn[k], sclk[k], din[k], fd[k]};
         tests++;
         if (actv !== expv) begin
            fails++;
            $display("FAIL cycle_cmp inst=%0d t=%0d got {rdy,cs_n,sclk,din,done}=%b expected %b",
                     k, cyc + 1, actv, expv);
         end

         if (!rst_n) begin
            cap[k] = '0; capn[k] = 0; gapc[k] = 0;
         end else begin
            if (sclk[k] && !psclk[k]) begin
               cap[k] = {cap[k][14:0], din[k]};
               capn[k]++;
            end
            if (fd[k]) begin
               check($sformatf("rise_count inst=%0d", k), capn[k], 16);
               check($sformatf("frame_word inst=%0d", k), int'(cap[k]), int'(mframe[k]));
               if (nw[k] < 64) begin
                  hist[k][nw[k]] = cap[k];
                  fdh[k][nw[k]] = cyc + 1;
               end
               nw[k]++;
               cap[k] = '0; capn[k] = 0;
            end
            if (csn[k] && !rdy[k]) gapc[k]++;
            if (rdy[k] && !prdy[k]) begin
               rdy_last[k] = cyc + 1;
               last_gap[k] = gapc[k];
               gapc[k] = 0;
            end
         end
         psclk[k] = sclk[k];
         prdy[k] = rdy[k];
      end
   end

   task automatic send(input int k, input logic [9:0] s, input bit hold);
      int c0, b;
      c0 = acc_cnt[k];
      b = 0;
      smp[k] = s;
      vld[k] = 1'b1;
      while (acc_cnt[k] == c0 && b < 2000) begin
         @(negedge clk);
         b++;
      end
      if (acc_cnt[k] == c0) begin
         tests++; fails++;
         $display("FAIL accept_timeout inst=%0d: got no accept, expected one", k);
      end
      if (!hold) vld[k] = 1'b0;
   endtask

   task automatic wait_words(input int k, input int n);
      int b;
      b = 0;
      while (nw[k] < n && b < 2000) begin
         @(negedge clk); #1;
         b++;
      end
      if (nw[k] < n) begin
         tests++; fails++;
         $display("FAIL frame_timeout inst=%0d: got %0d frames, expected %0d", k, nw[k], n);
      end
   endtask

   task automatic wait_idle(input int k);
      int b;
      b = 0;
      while (busy[k] && b < 2000) begin
         @(negedge clk);
         b++;
      end
      if (busy[k]) begin
         tests++; fails++;
         $display("FAIL idle_timeout inst=%0d: still busy, expected idle", k);
      end
   endtask

   task automatic random_frames(input int k, input int cnt);
      int b;
      for (int i = 0; i < cnt; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(k, 10'($urandom), 1'b0);
         b = 0;
         while (busy[k] && b < 2000) begin
            smp[k] = 10'($urandom);
            vld[k] = 1'($urandom);
            @(negedge clk);
            b++;
         end
         vld[k] = 1'b0;
      end
   endtask

   initial begin
      int ta, tb, tcc, w0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      fork
         begin
            send(0, 10'h3FF, 1'b1); ta = acc_last[0];
            send(0, 10'h155, 1'b1); tb = acc_last[0];
            send(0, 10'h2AA, 1'b0); tcc = acc_last[0];
            wait_words(0, 3);
            wait_idle(0);
            @(negedge clk);
            check("b2b_period_1", tb - ta, 67);
            check("b2b_period_2", tcc - tb, 67);
            check("word_3FF", int'(hist[0][0]), 16'h0FFC);
            check("word_155", int'(hist[0][1]), 16'h0554);
            check("word_2AA", int'(hist[0][2]), 16'h0AA8);
            check("done_time", fdh[0][0] - ta, 65);
            check("ready_return", rdy_last[0] - tcc, 67);
            check("cs_gap_cycles", last_gap[0], 2);
         end
         begin
            send(1, 10'h001, 1'b1); ta = acc_last[1];
            send(1, 10'h001, 1'b0); tb = acc_last[1];
            wait_words(1, 2);
            check("fast_period", tb - ta, 34);
            check("fast_word", int'(hist[1][0]), 16'h0004);
            check("fast_done_time", fdh[1][0] - ta, 33);
         end
         begin
            send(2, 10'h200, 1'b0);
            wait_idle(2);
            send(2, 10'h000, 1'b0);
            wait_words(2, 2);
            check("tc_word_neg512", int'(hist[2][0]), 16'h0000);
            check("tc_word_zero", int'(hist[2][1]), 16'h0800);
         end
      join

      fork
         random_frames(0, 12);
         random_frames(1, 12);
         random_frames(2, 12);
      join
      for (int k = 0; k < NI; k++) wait_idle(k);

      // Abort a frame after its 5th sclk rise.
      send(0, 10'h2AA, 1'b0);
      begin
         int b;
         b = 0;
         while (capn[0] < 5 && b < 500) begin
            @(negedge clk); #1;
            b++;
         end
         check("rises_before_abort", capn[0], 5);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_cs_n", int'(csn[0]), 1);
      check("abort_sclk", int'(sclk[0]), 0);
      check("abort_din", int'(din[0]), 0);
      check("abort_ready", int'(rdy[0]), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      w0 = nw[0];
      repeat (5) @(negedge clk);
      check("no_frame_without_handshake", int'(csn[0]), 1);
      send(0, 10'h0F0, 1'b0);
      wait_words(0, w0 + 1);
      check("post_abort_word", int'(hist[0][w0]), 16'h03C0);
      wait_idle(0);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dds_dac_tlc5615.md
# dds_dac_tlc5615

Serial DAC driver that sits directly downstream of the DDS waveform stage. It accepts 10-bit waveform samples over a valid/ready handshake and shifts each one out as a 16-bit frame to a TLC5615-class 10-bit serial DAC. The frame is 4 zero bits, 10 data bits MSB first, then 2 zero bits. It generates SCLK, DIN and CS_N from the system clock with a programmable divider.

## Interface
- CLK_DIV, 2, SCLK half-period in clk cycles (>=1)
- CS_GAP, 2, clk cycles CS_N is held high between frames (>=1)
- TWOS_COMP, 0, 1: input is two's complement, so sample[9] is inverted to offset binary before shifting
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sample  in  10  waveform sample from DDS ROM
- sample_valid  in  1  sample is valid
- sample_ready  out  1  block can accept a sample; equals (state==IDLE)
- dac_sclk  out  1  DAC serial clock, idles low
- dac_din  out  1  DAC serial data, changes on SCLK falling edge
- dac_cs_n  out  1  DAC chip select, active low
- frame_done  out  1  one-cycle pulse when a frame's last SCLK falling edge completes

## Operation
- States:
  - IDLE: cs_n=1, sclk=0, din=0, ready=1.
  - On sample_valid && sample_ready, the sample is latched at that edge.
    - shreg[15:0] = {4'b0, s, 2'b0}, where s = TWOS_COMP ? {~sample[9], sample[8:0]} : sample.
    - Next state is SHIFT.
  - SHIFT: cs_n=0. din = shreg[15].
    - div_cnt counts 0..CLK_DIV-1. A tick occurs at CLK_DIV-1, then div_cnt wraps to 0.
    - Each tick toggles sclk.
    - On a high-to-low toggle, shreg shifts left with 0 fill, and edge_cnt increments.
    - After the 16th falling toggle: sclk=0, cs_n=1, frame_done=1 for one cycle, state goes to GAP.
  - GAP: cs_n=1, din=0. gap_cnt counts CS_GAP cycles, then state goes to IDLE.
- Input changes after acceptance are ignored; only the latched shreg is shifted.
- sample_valid is ignored outside IDLE, and the handshake is not acknowledged. Upstream holds the sample or decimates.
- Counters:
  - div_cnt is wide enough for CLK_DIV-1.
  - edge_cnt is 5 bits, holding 0..16.
  - gap_cnt is wide enough for CS_GAP.
  - All counters clear on entry to each state.
- All outputs are registered except sample_ready, which is decoded from state.

## Timing
- Reset values are asserted asynchronously the moment rst_n falls:
  - state=IDLE, dac_cs_n=1, dac_sclk=0, dac_din=0, frame_done=0.
  - sample_ready reads 1, but no acceptance occurs while rst_n=0.
- Reset mid-frame aborts the frame immediately. The DAC sees CS_N rise and discards the partial word. A new frame starts only after a fresh handshake.
- Let t0 be the accept edge:
  - t0+1: cs_n=0, sclk=0, din=frame bit15, sample_ready=0.
  - SCLK rising edges occur at t0+1+(2k+1)*CLK_DIV, k=0..15. DAC samples DIN on these edges.
  - SCLK falling edges occur at t0+1+(2k+2)*CLK_DIV. din advances on each one.
  - t0+1+32*CLK_DIV: sclk=0, cs_n=1, frame_done=1.
  - t0+1+32*CLK_DIV+CS_GAP: state=IDLE, sample_ready=1.
- Frame period with back-to-back valid is 1+32*CLK_DIV+CS_GAP cycles. With defaults this is 67 cycles.
- Exactly 16 SCLK rising edges occur per frame. SCLK never toggles while cs_n=1.
- Valid held continuously in IDLE is accepted on the first IDLE edge. Accept and abort cannot coincide, because reset dominates.

## Test plan
- Reset, then sample=10'h3FF, valid=1 with defaults:
  - cs_n falls 1 cycle after accept.
  - DIN captured on the 16 SCLK rises is 0000_1111111111_00.
  - frame_done pulses at t0+65.
  - ready returns at t0+67.
- Two back-to-back samples 10'h155 then 10'h2AA, with valid held high:
  - Decoded words are 0x0554 and 0x0AA8.
  - cs_n is high for exactly 2 cycles between frames.
  - The second accept occurs at t0+67.
- CLK_DIV=1, CS_GAP=1, sample 10'h001:
  - SCLK period is 2 clk.
  - The frame is 0x0004.
  - Frame period is 34 cycles.
- TWOS_COMP=1, sample 10'h200 (−512) -> word 0x0000; sample 10'h000 -> word 0x0800.
- Assert rst_n low after the 5th SCLK rise:
  - cs_n=1, sclk=0 and din=0 at once, with no further SCLK edges.
  - After release, the next accepted 10'h0F0 produces a clean 0x03C0 frame.
- Change sample every cycle during SHIFT:
  - The shifted word equals the value latched at accept.
  - sample_ready stays 0 until GAP completes.
